alu_share_ctrl: RTL

- Sequencer/arbiter sharing one combinational ALU (add/sub/mult/shift/slt/logic, 4-bit op, 8-bit shamt, 64-bit hi/lo result, zero flag) between two requesters.
- Grants round-robin, registers operands, holds them stable for the op's execution time, captures hi/lo/zero, and returns them on a per-requester valid/ready response channel.
- Sits between issue logic (requester 0 = main pipe, requester 1 = auxiliary unit) and the ALU instance.

---
 rtl/alu_share_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Operands are latched and held for the op's execution time; results return on per-requester channels.
module alu_share_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic [7:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  input  logic [7:0]  req1_shamt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_hi,
  output logic [31:0] rsp0_lo,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_hi,
  output logic [31:0] rsp1_lo,
  output logic        rsp1_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_shamt,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  shamt_q, shamt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        zero_q, zero_d;

  logic        gnt;
  logic        accept;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_op;
  logic [7:0]  sel_shamt;
  logic        sel_mul;
  logic        rsp_take;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    if (req0_valid && req1_valid) gnt = ptr_q;
    else                          gnt = req1_valid;
  end

  assign accept     = (state_q == StIdle) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;

  assign sel_a     = gnt ? req1_a     : req0_a;
  assign sel_b     = gnt ? req1_b     : req0_b;
  assign sel_op    = gnt ? req1_op    : req0_op;
  assign sel_shamt = gnt ? req1_shamt : req0_shamt;
  assign sel_mul   = (sel_op == 4'b0110) || (sel_op == 4'b0111);

  assign rsp_take  = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = gnt;
          a_d     = sel_a;
          b_d     = sel_b;
          op_d    = sel_op;
          shamt_d = sel_shamt;
          cnt_d   = sel_mul ? MulCnt : 4'd0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = alu_hi;
          lo_d    = alu_lo;
          zero_d  = alu_zero;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_take) begin
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
    end
  end

  // The ALU only ever sees latched operands, so requesters may change freely after accept.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_shamt = shamt_q;

  assign rsp0_valid = (state_q == StResp) && !owner_q;
  assign rsp1_valid = (state_q == StResp) && owner_q;
  assign rsp0_hi    = hi_q;
  assign rsp0_lo    = lo_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_hi    = hi_q;
  assign rsp1_lo    = lo_q;
  assign rsp1_zero  = zero_q;

  assign busy = (state_q != StIdle);

endmodule
